// File: rtl/cordic_cos_sin_sched_if.sv
// cordic_cos_sin_sched_if
// Bundles the requester-side bus and the engine start/ready interface of the
// cos/sin scheduler. The scheduler uses the slave modport; whatever sits
// around it (clients plus engine, or a bench) uses the master modport.
interface cordic_cos_sin_sched_if #(
    parameter int NREQ      = 4,
    parameter int PHI_WIDTH = 16
);
    localparam int ID_WIDTH = $clog2(NREQ);

    logic [NREQ-1:0]             req;
    logic [NREQ*PHI_WIDTH-1:0]   phi;
    logic [NREQ-1:0]             ack;
    logic                        res_vld;
    logic [ID_WIDTH-1:0]         res_id;
    logic signed [PHI_WIDTH-1:0] cos;
    logic signed [PHI_WIDTH-1:0] sin;
    logic                        busy;

    logic                        eng_st;
    logic [PHI_WIDTH-1:0]        eng_phi;
    logic                        eng_rdy;
    logic signed [PHI_WIDTH-1:0] eng_cos;
    logic signed [PHI_WIDTH-1:0] eng_sin;

    modport slave (
        input  req, phi, eng_rdy, eng_cos, eng_sin,
        output ack, res_vld, res_id, cos, sin, busy, eng_st, eng_phi
    );

    modport master (
        output req, phi, eng_rdy, eng_cos, eng_sin,
        input  ack, res_vld, res_id, cos, sin, busy, eng_st, eng_phi
    );
endinterface

// File: rtl/cordic_cos_sin_sched.sv
// cordic_cos_sin_sched
// Shares one serial CORDIC cos/sin engine between NREQ requesters. A request
// is granted only in IDLE while the engine reports ready, the angle is handed
// to the engine with a one-cycle start pulse, and the result is registered and
// tagged with the requester index when the engine becomes ready again.
//
// Build option: define CORDIC_SCHED_RR_EN for round-robin arbitration;
// without it the lowest requester index always wins and no pointer exists.
//
// state | meaning
// IDLE  | waiting for engine ready and a pending request
// START | eng_st and ack high for this cycle only
// BUSY  | engine computing, waiting for eng_rdy
module cordic_cos_sin_sched #(
    parameter int NREQ      = 4,
    parameter int PHI_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    cordic_cos_sin_sched_if.slave  bus
);
    localparam int ID_WIDTH = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [ID_WIDTH-1:0]    gid_q;
    logic [ID_WIDTH-1:0]    res_id_q;
    logic [NREQ-1:0]        ack_q;
    logic                   eng_st_q;
    logic                   busy_q;
    logic                   res_vld_q;
    logic [PHI_WIDTH-1:0]   eng_phi_q;
    logic [PHI_WIDTH-1:0]   cos_q;
    logic [PHI_WIDTH-1:0]   sin_q;

    logic                   grant_vld_d;
    logic [ID_WIDTH-1:0]    grant_id_d;
    logic [PHI_WIDTH-1:0]   grant_phi_d;

`ifdef CORDIC_SCHED_RR_EN
    logic [ID_WIDTH-1:0]    ptr_q;
    logic [ID_WIDTH-1:0]    ptr_d;

    // Round-robin search starting at the pointer, wrapping modulo NREQ.
    always_comb begin
        int idx;
        grant_vld_d = 1'b0;
        grant_id_d  = '0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!grant_vld_d && bus.req[idx]) begin
                grant_vld_d = 1'b1;
                grant_id_d  = ID_WIDTH'(idx);
            end
        end
    end

    // Pointer moves just past the winner; explicit wrap covers non-power-of-2 NREQ.
    assign ptr_d = (grant_id_d == ID_WIDTH'(NREQ - 1)) ? '0
                                                       : grant_id_d + ID_WIDTH'(1);
`else
    // Fixed priority: lowest requester index wins.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_id_d  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                grant_vld_d = 1'b1;
                grant_id_d  = ID_WIDTH'(k);
            end
        end
    end
`endif

    assign grant_phi_d = bus.phi[int'(grant_id_d) * PHI_WIDTH +: PHI_WIDTH];

    // Scheduler FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            gid_q     <= '0;
            res_id_q  <= '0;
            ack_q     <= '0;
            eng_st_q  <= 1'b0;
            busy_q    <= 1'b0;
            res_vld_q <= 1'b0;
            eng_phi_q <= '0;
            cos_q     <= '0;
            sin_q     <= '0;
`ifdef CORDIC_SCHED_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            res_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Engine ready is required so a start never lands mid-computation.
                    if (bus.eng_rdy && grant_vld_d) begin
                        gid_q     <= grant_id_d;
                        eng_phi_q <= grant_phi_d;
                        eng_st_q  <= 1'b1;
                        ack_q     <= NREQ'(1) << grant_id_d;
                        busy_q    <= 1'b1;
                        state_q   <= START;
`ifdef CORDIC_SCHED_RR_EN
                        ptr_q     <= ptr_d;
`endif
                    end
                end
                START: begin
                    // eng_rdy is still high from before the start; do not look at it here.
                    eng_st_q <= 1'b0;
                    ack_q    <= '0;
                    state_q  <= BUSY;
                end
                BUSY: begin
                    if (bus.eng_rdy) begin
                        cos_q     <= bus.eng_cos;
                        sin_q     <= bus.eng_sin;
                        res_id_q  <= gid_q;
                        res_vld_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack     = ack_q;
    assign bus.res_vld = res_vld_q;
    assign bus.res_id  = res_id_q;
    assign bus.cos     = cos_q;
    assign bus.sin     = sin_q;
    assign bus.busy    = busy_q;
    assign bus.eng_st  = eng_st_q;
    assign bus.eng_phi = eng_phi_q;
endmodule

// File: tb/tb_cordic_cos_sin_sched.sv
// tb_cordic_cos_sin_sched
// Directed bench for the cos/sin scheduler with a behavioural 14-iteration
// engine: rdy falls the cycle after st is sampled and returns 16 cycles after
// that sample; results are a fixed function of the latched angle and read as
// garbage while the engine is computing.
`timescale 1ns/1ps
module tb_cordic_cos_sin_sched;
    localparam int NREQ   = 4;
    localparam int PW     = 16;
    localparam int N_ITER = 14;
    localparam int BUDGET = 60;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    cordic_cos_sin_sched_if #(.NREQ(NREQ), .PHI_WIDTH(PW)) bus ();

    cordic_cos_sin_sched #(.NREQ(NREQ), .PHI_WIDTH(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] f_cos(input logic [PW-1:0] a);
        return a * 16'd3 + 16'd1;
    endfunction

    function automatic logic [PW-1:0] f_sin(input logic [PW-1:0] a);
        return ~a ^ 16'h1234;
    endfunction

    // Engine model
    logic          eng_rdy_m;
    logic [4:0]    eng_cnt;
    logic [PW-1:0] eng_lat;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_rdy_m <= 1'b0;
            eng_cnt   <= '0;
            eng_lat   <= '0;
        end else if (bus.eng_st && eng_rdy_m) begin
            eng_rdy_m <= 1'b0;
            eng_cnt   <= 5'(N_ITER + 1);
            eng_lat   <= bus.eng_phi;
        end else if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 5'd1;
            if (eng_cnt == 5'd1) eng_rdy_m <= 1'b1;
        end else begin
            eng_rdy_m <= 1'b1;
        end
    end

    assign bus.eng_rdy = eng_rdy_m;
    assign bus.eng_cos = eng_rdy_m ? f_cos(eng_lat) : 16'hDEAD;
    assign bus.eng_sin = eng_rdy_m ? f_sin(eng_lat) : 16'hBEEF;

    task automatic apply_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus.req = '0;
        bus.phi = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ack(output logic [NREQ-1:0] a, output int c, output bit to);
        to = 1'b1;
        a  = '0;
        c  = 0;
        for (int i = 0; i < BUDGET && to; i++) begin
            @(negedge clk);
            if (bus.ack != '0) begin
                a  = bus.ack;
                c  = cyc;
                to = 1'b0;
            end
        end
    endtask

    task automatic wait_res(output int c, output bit to, output logic [NREQ-1:0] seen);
        to   = 1'b1;
        c    = 0;
        seen = '0;
        for (int i = 0; i < BUDGET && to; i++) begin
            @(negedge clk);
            seen = seen | bus.ack;
            if (bus.res_vld) begin
                c  = cyc;
                to = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req = '0;
        bus.phi = '0;
        @(negedge clk);
        checks++;
        if ({bus.ack, bus.res_vld, bus.res_id, bus.cos, bus.sin, bus.busy, bus.eng_st, bus.eng_phi} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b vld=%b id=%0d cos=%h sin=%h busy=%b st=%b phi=%h",
                     bus.ack, bus.res_vld, bus.res_id, bus.cos, bus.sin, bus.busy, bus.eng_st, bus.eng_phi);
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] a, seen;
        int ca, cr, crel;
        bit to;
        apply_reset();
        crel = cyc;
        bus.req[2] = 1'b1;
        bus.phi[2*PW +: PW] = 16'h2000;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0000) begin
            errors++;
            $display("FAIL no_grant_after_reset: ack=%b expected 0000", bus.ack);
        end
        wait_ack(a, ca, to);
        checks++;
        if (to || a !== 4'b0100) begin
            errors++;
            $display("FAIL single_ack: ack=%b timeout=%0d expected 0100", a, to);
        end
        checks++;
        if (ca - crel !== 2) begin
            errors++;
            $display("FAIL single_ack_time: %0d cycles after release, expected 2", ca - crel);
        end
        checks++;
        if (bus.eng_st !== 1'b1 || bus.eng_phi !== 16'h2000 || eng_rdy_m !== 1'b1) begin
            errors++;
            $display("FAIL single_start: st=%b phi=%h eng_rdy=%b expected 1 2000 1", bus.eng_st, bus.eng_phi, eng_rdy_m);
        end
        bus.req[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ack !== 4'b0000 || bus.eng_st !== 1'b0 || bus.busy !== 1'b1 || bus.eng_phi !== 16'h2000) begin
            errors++;
            $display("FAIL single_busy: ack=%b st=%b busy=%b phi=%h expected 0000 0 1 2000",
                     bus.ack, bus.eng_st, bus.busy, bus.eng_phi);
        end
        wait_res(cr, to, seen);
        checks++;
        if (to || cr - ca !== 17) begin
            errors++;
            $display("FAIL single_latency: res_vld %0d cycles after ack (timeout=%0d), expected 17", cr - ca, to);
        end
        checks++;
        if (bus.res_id !== 2'd2 || bus.cos !== f_cos(16'h2000) || bus.sin !== f_sin(16'h2000)) begin
            errors++;
            $display("FAIL single_result: id=%0d cos=%h sin=%h expected 2 %h %h",
                     bus.res_id, bus.cos, bus.sin, f_cos(16'h2000), f_sin(16'h2000));
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle_on_vld: busy=%b expected 0", bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.res_vld !== 1'b0 || bus.cos !== f_cos(16'h2000)) begin
            errors++;
            $display("FAIL single_vld_pulse: vld=%b cos=%h expected 0 %h", bus.res_vld, bus.cos, f_cos(16'h2000));
        end
    endtask

    task automatic test_all_four();
        logic [NREQ-1:0] a, seen;
        logic [PW-1:0] cur_phi [NREQ];
        logic [PW-1:0] ang;
        int exp_id [5];
        int ca, cr, g;
        bit to, zero_again;
`ifdef CORDIC_SCHED_RR_EN
        exp_id = '{0, 1, 2, 3, 0};
`else
        exp_id = '{0, 0, 1, 2, 3};
`endif
        cur_phi = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        zero_again = 1'b1;
        apply_reset();
        for (int i = 0; i < NREQ; i++) bus.phi[i*PW +: PW] = cur_phi[i];
        bus.req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            g = exp_id[j];
            wait_ack(a, ca, to);
            checks++;
            if (to || a !== (4'b0001 << g)) begin
                errors++;
                $display("FAIL arb_order[%0d]: ack=%b timeout=%0d expected id %0d", j, a, to, g);
            end
            ang = cur_phi[g];
            if (g == 0 && zero_again) begin
                zero_again = 1'b0;
                cur_phi[0] = 16'h0F0F;
                bus.phi[0 +: PW] = 16'h0F0F;
            end else begin
                bus.req[g] = 1'b0;
            end
            wait_res(cr, to, seen);
            checks++;
            if (to || bus.res_id !== 2'(g) || bus.cos !== f_cos(ang) || bus.sin !== f_sin(ang)) begin
                errors++;
                $display("FAIL arb_result[%0d]: id=%0d cos=%h sin=%h expected %0d %h %h",
                         j, bus.res_id, bus.cos, bus.sin, g, f_cos(ang), f_sin(ang));
            end
        end
        bus.req = '0;
    endtask

    task automatic test_back_to_back();
        logic [NREQ-1:0] a, seen;
        logic [PW-1:0] angs [4];
        int ca, cr, prev_cr;
        bit to;
        angs = '{16'h1000, 16'h3333, 16'h7FFF, 16'h9ABC};
        prev_cr = 0;
        @(negedge clk);
        bus.phi[1*PW +: PW] = angs[0];
        bus.req[1] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_ack(a, ca, to);
            checks++;
            if (to || a !== 4'b0010) begin
                errors++;
                $display("FAIL b2b_ack[%0d]: ack=%b timeout=%0d expected 0010", j, a, to);
            end
            if (j > 0) begin
                checks++;
                if (ca - prev_cr !== 1) begin
                    errors++;
                    $display("FAIL b2b_regrant[%0d]: ack %0d cycles after res_vld, expected 1", j, ca - prev_cr);
                end
            end
            if (j < 3) bus.phi[1*PW +: PW] = angs[j+1];
            else       bus.req[1] = 1'b0;
            wait_res(cr, to, seen);
            checks++;
            if (to || bus.res_id !== 2'd1 || bus.cos !== f_cos(angs[j]) || bus.sin !== f_sin(angs[j])) begin
                errors++;
                $display("FAIL b2b_result[%0d]: id=%0d cos=%h sin=%h expected 1 %h %h",
                         j, bus.res_id, bus.cos, bus.sin, f_cos(angs[j]), f_sin(angs[j]));
            end
            if (j > 0) begin
                checks++;
                if (cr - prev_cr !== 18) begin
                    errors++;
                    $display("FAIL b2b_interval[%0d]: %0d cycles between res_vld, expected 18", j, cr - prev_cr);
                end
            end
            prev_cr = cr;
        end
    endtask

    task automatic test_withdraw();
        logic [NREQ-1:0] a, seen, seen_all;
        int ca, cr;
        bit to;
        seen_all = '0;
        @(negedge clk);
        bus.phi[0 +: PW] = 16'h5A5A;
        bus.req[0] = 1'b1;
        wait_ack(a, ca, to);
        checks++;
        if (to || a !== 4'b0001) begin
            errors++;
            $display("FAIL wd_ack: ack=%b timeout=%0d expected 0001", a, to);
        end
        bus.req[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen_all = seen_all | bus.ack;
        end
        bus.phi[3*PW +: PW] = 16'h6666;
        bus.req[3] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            seen_all = seen_all | bus.ack;
        end
        bus.req[3] = 1'b0;
        wait_res(cr, to, seen);
        seen_all = seen_all | seen;
        checks++;
        if (to || bus.res_id !== 2'd0 || bus.cos !== f_cos(16'h5A5A)) begin
            errors++;
            $display("FAIL wd_result: id=%0d cos=%h timeout=%0d expected 0 %h", bus.res_id, bus.cos, to, f_cos(16'h5A5A));
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen_all = seen_all | bus.ack;
            checks++;
            if (bus.busy !== 1'b0 || bus.eng_st !== 1'b0 || bus.res_vld !== 1'b0) begin
                errors++;
                $display("FAIL wd_stay_idle[%0d]: busy=%b st=%b vld=%b expected 0 0 0", i, bus.busy, bus.eng_st, bus.res_vld);
            end
        end
        checks++;
        if (seen_all !== 4'b0000) begin
            errors++;
            $display("FAIL wd_no_ack: acks seen=%b expected 0000", seen_all);
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ-1:0] a, seen;
        int ca, cr, stray;
        bit to;
        stray = 0;
        @(negedge clk);
        bus.phi[1*PW +: PW] = 16'h2468;
        bus.req[1] = 1'b1;
        wait_ack(a, ca, to);
        checks++;
        if (to || a !== 4'b0010) begin
            errors++;
            $display("FAIL rst_mid_ack: ack=%b timeout=%0d expected 0010", a, to);
        end
        bus.req[1] = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.ack, bus.res_vld, bus.res_id, bus.cos, bus.sin, bus.busy, bus.eng_st, bus.eng_phi} !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: ack=%b vld=%b id=%0d cos=%h sin=%h busy=%b st=%b phi=%h",
                     bus.ack, bus.res_vld, bus.res_id, bus.cos, bus.sin, bus.busy, bus.eng_st, bus.eng_phi);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.res_vld || bus.ack != '0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL rst_mid_job_lost: %0d cycles with res_vld/ack, expected 0", stray);
        end
        bus.phi[2*PW +: PW] = 16'h1357;
        bus.req[2] = 1'b1;
        wait_ack(a, ca, to);
        checks++;
        if (to || a !== 4'b0100) begin
            errors++;
            $display("FAIL rst_mid_new_ack: ack=%b timeout=%0d expected 0100", a, to);
        end
        bus.req[2] = 1'b0;
        wait_res(cr, to, seen);
        checks++;
        if (to || cr - ca !== 17 || bus.res_id !== 2'd2 || bus.cos !== f_cos(16'h1357) || bus.sin !== f_sin(16'h1357)) begin
            errors++;
            $display("FAIL rst_mid_new_result: lat=%0d id=%0d cos=%h sin=%h expected 17 2 %h %h",
                     cr - ca, bus.res_id, bus.cos, bus.sin, f_cos(16'h1357), f_sin(16'h1357));
        end
    endtask

    task automatic test_boundary();
        logic [NREQ-1:0] a, seen;
        logic [PW-1:0] angs [4];
        int ca, cr, prev_cr;
        bit to;
        angs = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
        prev_cr = 0;
        apply_reset();
        for (int i = 0; i < NREQ; i++) bus.phi[i*PW +: PW] = angs[i];
        bus.req = 4'b1111;
        for (int j = 0; j < NREQ; j++) begin
            wait_ack(a, ca, to);
            checks++;
            if (to || a !== (4'b0001 << j)) begin
                errors++;
                $display("FAIL bnd_ack[%0d]: ack=%b timeout=%0d expected id %0d", j, a, to, j);
            end
            if (j > 0) begin
                checks++;
                if (ca - prev_cr !== 1) begin
                    errors++;
                    $display("FAIL bnd_regrant[%0d]: ack %0d cycles after res_vld, expected 1", j, ca - prev_cr);
                end
            end
            bus.req[j] = 1'b0;
            wait_res(cr, to, seen);
            checks++;
            if (to || bus.res_id !== 2'(j) || bus.cos !== f_cos(angs[j]) || bus.sin !== f_sin(angs[j])) begin
                errors++;
                $display("FAIL bnd_result[%0d]: id=%0d cos=%h sin=%h expected %0d %h %h",
                         j, bus.res_id, bus.cos, bus.sin, j, f_cos(angs[j]), f_sin(angs[j]));
            end
            prev_cr = cr;
        end
    endtask

    initial begin
        bus.req = '0;
        bus.phi = '0;
        test_reset();
        test_single();
        test_all_four();
        test_back_to_back();
        test_withdraw();
        test_reset_mid();
        test_boundary();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cordic_cos_sin_sched.md
# cordic_cos_sin_sched

- Shares one serial CORDIC cos/sin engine between `NREQ` requesters.
- Arbitrates pending requests, drives the engine's `st`/`phi` start interface and waits for its `rdy`.
- Returns the registered `cos`/`sin` result, tagged with the requester index.
- Sits between DSP clients (NCOs, mixers) and a single engine instance, so area stays that of one engine.

## Interface
- `NREQ`, 4: number of requesters; must be ≥ 2.
- `PHI_WIDTH`, 16: angle and result width; must match the engine.
- `ID_WIDTH`, `$clog2(NREQ)`: width of the requester index (localparam).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  `NREQ`  request per requester; held high with `phi` stable until `ack`.
- `phi`  in  `NREQ*PHI_WIDTH`  flat angle bus; requester i occupies `[i*PHI_WIDTH +: PHI_WIDTH]`.
- `ack`  out  `NREQ`  one-hot, one-cycle pulse: the angle was consumed.
- `res_vld`  out  1  one-cycle pulse: `res_id`, `cos` and `sin` are valid.
- `res_id`  out  `ID_WIDTH`  requester index of the current result.
- `cos`, `sin`  out  `PHI_WIDTH`  signed result; holds until the next `res_vld`.
- `busy`  out  1  high in every state except IDLE.
- `eng_st`  out  1  engine start pulse.
- `eng_phi`  out  `PHI_WIDTH`  engine angle.
- `eng_rdy`  in  1  engine ready.
- `eng_cos`, `eng_sin`  in  `PHI_WIDTH`  engine result.

## Operation
- Reset: all outputs are registers and clear to 0; state = IDLE; round-robin pointer = 0.
- FSM states: IDLE, START, BUSY.
- **IDLE**
  - If `eng_rdy=1` and `|req`, select winner g.
  - Register `gid<=g`, `eng_phi<=phi[g]`, `eng_st<=1`, `ack[g]<=1`, go to START.
  - Otherwise stay in IDLE.
- **START**
  - `eng_st` and `ack` are high for exactly this cycle; the engine samples `st` at the closing edge.
  - Clear `eng_st` and `ack`, go to BUSY.
  - `eng_rdy` is not examined in START.
- **BUSY**
  - On `eng_rdy=1`: `cos<=eng_cos`, `sin<=eng_sin`, `res_id<=gid`, `res_vld<=1`, go to IDLE.
  - `res_vld` clears the following cycle.
- Requests arriving while not in IDLE stay pending; none are dropped.
- Dropping `req` before `ack` withdraws the request. Sampling happens only in the IDLE cycle.
- `eng_phi` holds its value after START.
- `phi` bits of a non-granted requester are ignored.
- `eng_st` is never asserted while the engine is busy. A restart mid-computation is illegal and must not occur.

## Timing
- Engine of N iterations: `rdy` falls the cycle after `st` is sampled and returns N+2 cycles after that sample.
- Latency: req sampled in IDLE at cycle t, so `ack` at t+1 and `res_vld` at t+N+4.
- Throughput: one job per N+4 cycles. IDLE is re-entered in the `res_vld` cycle, so a pending request is granted in that same cycle.
- After reset, the engine's `rdy` is 0 for one cycle, so no grant occurs in the first cycle after reset release.
- Reset mid-operation: block and engine share `reset`. The job is lost with no `ack` and no `res_vld`, and the requester must re-request.
- `ack` and `res_vld` of different jobs never coincide: `ack` falls in START, `res_vld` rises after BUSY.

## Configuration
- Macro: `CORDIC_SCHED_RR_EN`.
- Defined: round-robin arbitration.
  - Search starts at `ptr` and wraps modulo `NREQ`.
  - On grant, `ptr <= g+1`, wrapping to 0 after `NREQ-1`.
- Undefined: fixed priority, lowest index wins. The pointer logic is absent.

## Test plan
- Single request: `NREQ=4`, `PHI_WIDTH=16`, N=14; `req[2]=1`, `phi[2]=16'h2000`.
  - `ack=4'b0100` one cycle later; `res_vld` 18 cycles after the req sample with `res_id=2`.
  - `cos`/`sin` bit-exact with a standalone engine driven by `16'h2000`.
- All four requesters held high with distinct angles.
  - RR build: grant order 0,1,2,3.
  - Non-RR build: requester 0 wins every arbitration while held, and 1..3 are served only after it drops.
- Back-to-back: `req[1]` held continuously with `phi` updated on each `ack`.
  - Successive `res_vld` pulses are exactly 18 cycles apart; each result matches its angle.
- Withdrawal: `req[3]` pulsed high for 2 cycles while BUSY serves requester 0.
  - No `ack[3]`, no result with id 3; the next IDLE with no request stays IDLE.
- Reset mid-BUSY: assert `reset` 5 cycles after `ack`.
  - All outputs 0 immediately; no `res_vld`; a new request after release completes normally.
- Boundary angles `16'h0000`, `16'h4000`, `16'h8000`, `16'hC000` through requesters 0..3.
  - Results bit-exact with the standalone engine; `res_id` tags are correct.
